sprite_blitter: RTL and testbench



---
 rtl/graphics_pkg.sv | 29 ++
 rtl/sprite_byte_unpacker.sv | 53 +++++
 rtl/sprite_blitter.sv | 164 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared types for the sprite engine: colour modes, blitter states and
// the bytes-to-pixels helper.
package graphics_pkg;

    typedef enum logic [1:0] {
        CM_1BPP = 2'b00,
        CM_2BPP = 2'b01,
        CM_4BPP = 2'b10,
        CM_RSVD = 2'b11
    } color_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } blit_state_t;

    // Reserved mode yields zero pixels so its bytes are swallowed silently.
    function automatic logic [3:0] pixels_per_byte(input color_mode_t mode);
        case (mode)
            CM_1BPP: return 4'd8;
            CM_2BPP: return 4'd4;
            CM_4BPP: return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_byte_unpacker.sv
// Serialises one packed sprite byte into MSB-first palette indices,
// one per clock, flagging the final index of the byte.
module sprite_byte_unpacker
    import graphics_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    input  color_mode_t i_mode,
    output logic        o_pix_valid,
    output logic [3:0]  o_pix_index,
    output logic        o_pix_last
);

    logic [7:0] r_shift;
    logic [3:0] r_count;

    assign o_pix_valid = (r_count != 4'd0);
    assign o_pix_last  = (r_count == 4'd1);

    always_comb begin
        o_pix_index = 4'd0;
        case (i_mode)
            CM_1BPP: o_pix_index = {3'b000, r_shift[7]};
            CM_2BPP: o_pix_index = {2'b00, r_shift[7:6]};
            CM_4BPP: o_pix_index = r_shift[7:4];
            default: o_pix_index = 4'd0;
        endcase
    end

    // A load always coincides with the previous byte being empty or on its
    // last index, so loading implicitly consumes that index.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shift <= i_byte;
            r_count <= pixels_per_byte(i_mode);
        end else if (o_pix_valid) begin
            r_count <= r_count - 4'd1;
            case (i_mode)
                CM_1BPP: r_shift <= {r_shift[6:0], 1'b0};
                CM_2BPP: r_shift <= {r_shift[5:0], 2'b00};
                CM_4BPP: r_shift <= {r_shift[3:0], 4'b0000};
                default: r_shift <= r_shift;
            endcase
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite engine: unpacks a byte stream into clipped frame-buffer pixel writes.
// Optional SPRITE_BLITTER_TRANSPARENCY_EN: raw index 0 suppresses the write.
module sprite_blitter
    import graphics_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 400,
    parameter int COORD_WIDTH    = 10,
    parameter int ADDRESS_WIDTH  = 18,
    parameter int COLOR_DEPTH    = 4
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [COORD_WIDTH-1:0]   cursor_start_x_position_in,
    input  logic [COORD_WIDTH-1:0]   cursor_start_y_position_in,
    input  logic [COORD_WIDTH-1:0]   draw_width_in,
    input  logic [1:0]               color_mode_in,
    input  logic [3:0]               color_pallet_offset_in,
    input  logic                     sprite_draw_enable_in,
    input  logic                     sprite_data_valid_in,
    output logic                     sprite_data_ready_out,
    input  logic [7:0]               sprite_data_in,
    input  logic                     sprite_data_last_in,
    output logic                     pixel_write_enable_out,
    output logic [ADDRESS_WIDTH-1:0] pixel_write_address_out,
    output logic [COLOR_DEPTH-1:0]   pixel_write_data_out,
    output logic                     cursor_end_position_valid_out,
    output logic [COORD_WIDTH-1:0]   cursor_end_x_position_out,
    output logic [COORD_WIDTH-1:0]   cursor_end_y_position_out
);

    blit_state_t              r_state, w_state_nxt;
    logic                     r_en_d;
    logic [COORD_WIDTH-1:0]   r_left, r_right, r_x, r_y;
    color_mode_t              r_mode;
    logic [3:0]               r_offset;
    logic                     r_last_seen;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [COLOR_DEPTH-1:0]   r_data;
    logic                     r_end_valid;
    logic [COORD_WIDTH-1:0]   r_end_x, r_end_y;

    logic                     w_en, w_start, w_consume, w_ready, w_accept;
    logic                     w_clip, w_transparent;
    logic                     w_pix_valid, w_pix_last;
    logic [3:0]               w_pix_index;
    logic [COORD_WIDTH-1:0]   w_width_eff;
    logic [COLOR_DEPTH-1:0]   w_data;
    logic [ADDRESS_WIDTH-1:0] w_addr;

    assign w_en        = sprite_draw_enable_in;
    assign w_width_eff = (draw_width_in == '0) ? COORD_WIDTH'(1) : draw_width_in;
    assign w_start     = (r_state == ST_IDLE) && w_en && !r_en_d;
    assign w_consume   = (r_state == ST_RUN) && w_en && w_pix_valid;
    // Taking a byte on the last index keeps full-rate streams gap-free.
    assign w_ready     = (r_state == ST_RUN) && w_en && !r_last_seen &&
                         (!w_pix_valid || w_pix_last);
    assign w_accept    = w_ready && sprite_data_valid_in;

    assign w_clip = ({1'b0, r_x} >= (COORD_WIDTH+1)'(DISPLAY_WIDTH)) ||
                    ({1'b0, r_y} >= (COORD_WIDTH+1)'(DISPLAY_HEIGHT));
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    assign w_transparent = (w_pix_index == 4'd0);
`else
    assign w_transparent = 1'b0;
`endif

    assign w_data = COLOR_DEPTH'(w_pix_index) + COLOR_DEPTH'(r_offset);
    assign w_addr = ADDRESS_WIDTH'(r_y) * ADDRESS_WIDTH'(DISPLAY_WIDTH) + ADDRESS_WIDTH'(r_x);

    sprite_byte_unpacker u_unpacker (
        .i_clk       (clock_in),
        .i_rst       (reset_in),
        .i_clear     (r_state != ST_RUN),
        .i_load      (w_accept),
        .i_byte      (sprite_data_in),
        .i_mode      (r_mode),
        .o_pix_valid (w_pix_valid),
        .o_pix_index (w_pix_index),
        .o_pix_last  (w_pix_last)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!w_en)
                    w_state_nxt = ST_IDLE;
                else if ((w_consume && w_pix_last && r_last_seen) ||
                         (w_accept && sprite_data_last_in && pixels_per_byte(r_mode) == 4'd0))
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: w_state_nxt = w_en ? ST_DONE : ST_IDLE;
            ST_DONE:  if (!w_en) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_en_d      <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= CM_1BPP;
            r_offset    <= '0;
            r_last_seen <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_end_valid <= 1'b0;
            r_end_x     <= '0;
            r_end_y     <= '0;
        end else begin
            r_en_d      <= w_en;
            r_we        <= w_consume && !w_clip && !w_transparent;
            r_end_valid <= (r_state == ST_FLUSH) && w_en;
            if (w_start) begin
                r_left      <= cursor_start_x_position_in;
                r_right     <= cursor_start_x_position_in + w_width_eff - COORD_WIDTH'(1);
                r_x         <= cursor_start_x_position_in;
                r_y         <= cursor_start_y_position_in;
                r_mode      <= color_mode_t'(color_mode_in);
                r_offset    <= color_pallet_offset_in;
                r_last_seen <= 1'b0;
            end else begin
                if (w_accept && sprite_data_last_in)
                    r_last_seen <= 1'b1;
                if (w_consume) begin
                    r_addr <= w_addr;
                    r_data <= w_data;
                    if (r_x == r_right) begin
                        r_x <= r_left;
                        r_y <= r_y + COORD_WIDTH'(1);
                    end else begin
                        r_x <= r_x + COORD_WIDTH'(1);
                    end
                end
            end
            // Cursor has settled on the post-sprite position by FLUSH.
            if ((r_state == ST_FLUSH) && w_en) begin
                r_end_x <= r_x;
                r_end_y <= r_y;
            end
        end
    end

    assign sprite_data_ready_out          = w_ready;
    assign pixel_write_enable_out         = r_we;
    assign pixel_write_address_out        = r_addr;
    assign pixel_write_data_out           = r_data;
    assign cursor_end_position_valid_out  = r_end_valid;
    assign cursor_end_x_position_out      = r_end_x;
    assign cursor_end_y_position_out      = r_end_y;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter against a pixel-list reference model.
module tb_sprite_blitter;

    localparam int DW = 640;
    localparam int DH = 400;

    logic        clk;
    logic        rst;
    logic [9:0]  sx_in, sy_in, w_in;
    logic [1:0]  mode_in;
    logic [3:0]  off_in;
    logic        en, valid, last;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [17:0] addr;
    logic [3:0]  wdata;
    logic        end_valid;
    logic [9:0]  end_x, end_y;

    sprite_blitter dut (
        .clock_in                      (clk),
        .reset_in                      (rst),
        .cursor_start_x_position_in    (sx_in),
        .cursor_start_y_position_in    (sy_in),
        .draw_width_in                 (w_in),
        .color_mode_in                 (mode_in),
        .color_pallet_offset_in        (off_in),
        .sprite_draw_enable_in         (en),
        .sprite_data_valid_in          (valid),
        .sprite_data_ready_out         (ready),
        .sprite_data_in                (data),
        .sprite_data_last_in           (last),
        .pixel_write_enable_out        (we),
        .pixel_write_address_out       (addr),
        .pixel_write_data_out          (wdata),
        .cursor_end_position_valid_out (end_valid),
        .cursor_end_x_position_out     (end_x),
        .cursor_end_y_position_out     (end_y)
    );

    typedef struct { int addr; int data; } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, wr_cnt = 0, end_cnt = 0, first_cyc = 0, last_cyc = 0;
    int exp_end_x = 0, exp_end_y = 0;
    logic prev_end = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk every pixel of the sprite in order and list the writes.
    task automatic model(input int sx, input int sy, input int w, input int mode, input int off);
        int x, y, right, bpp, ppb, idx;
        bit wr;
        exp_q.delete();
        x = sx; y = sy;
        right = (sx + ((w == 0) ? 1 : w) - 1) % 1024;
        if (mode != 3) begin
            bpp = 1 << mode;
            ppb = 8 / bpp;
            foreach (bq[i]) begin
                for (int p = 0; p < ppb; p++) begin
                    idx = (int'(bq[i]) >> (8 - bpp * (p + 1))) & ((1 << bpp) - 1);
                    wr = (x < DW) && (y < DH);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
                    if (idx == 0) wr = 1'b0;
`endif
                    if (wr) exp_q.push_back('{y * DW + x, (idx + off) % 16});
                    if (x == right) begin
                        x = sx;
                        y = (y + 1) % 1024;
                    end else begin
                        x = (x + 1) % 1024;
                    end
                end
            end
        end
        exp_end_x = x;
        exp_end_y = y;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                wr_cnt++;
                if (wr_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", addr, e.addr);
                    chk("wr_data", wdata, e.data);
                end
            end
            if (end_valid) begin
                end_cnt++;
                chk("end_x", end_x, exp_end_x);
                chk("end_y", end_y, exp_end_y);
                chk("end_pulse_width", prev_end, 0);
            end
            prev_end = end_valid;
        end
    end

    task automatic setup(input int sx, input int sy, input int w, input int mode, input int off);
        model(sx, sy, w, mode, off);
        sx_in = 10'(sx); sy_in = 10'(sy); w_in = 10'(w);
        mode_in = 2'(mode); off_in = 4'(off);
        wr_cnt = 0;
    endtask

    task automatic run_sprite(input int sx, input int sy, input int w, input int mode,
                              input int off, input int gap_pct);
        int ends0;
        bit ok;
        setup(sx, sy, w, mode, off);
        ends0 = end_cnt;
        en = 1'b1;
        for (int i = 0; i < bq.size(); i++) begin
            while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                valid = 1'b0;
                @(posedge clk); #1;
            end
            valid = 1'b1;
            data  = bq[i];
            last  = (i == bq.size() - 1);
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        for (int t = 0; t < 200 && end_cnt == ends0; t++) begin
            @(posedge clk); #1;
        end
        chk("end_pulse_seen", end_cnt - ends0, 1);
        chk("writes_left", exp_q.size(), 0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("end_hold_x", end_x, exp_end_x);
        chk("end_hold_y", end_y, exp_end_y);
        exp_q.delete();
    endtask

    initial begin
        int ends0;
        rst = 1'b1; en = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
        sx_in = '0; sy_in = '0; w_in = '0; mode_in = '0; off_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_ready", ready, 0);
        chk("rst_end_valid", end_valid, 0);
        chk("rst_end_x", end_x, 0);
        chk("rst_end_y", end_y, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1bpp byte at the origin
        bq = '{8'hA5};
        run_sprite(0, 0, 8, 0, 0, 0);
        chk("t1_end_y_const", end_y, 1);

        // 4bpp with offset and line wrap
        bq = '{8'h12, 8'h34};
        run_sprite(10, 2, 3, 2, 2, 0);
        chk("t2_end_x_const", end_x, 11);

        // 2bpp straddling the right edge of the display
        bq = '{8'hE4};
        run_sprite(638, 0, 4, 1, 0, 0);

        // Full-rate stream: 32 writes on consecutive cycles
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_sprite(100, 50, 16, 0, 3, 0);
        chk("b2b_count", wr_cnt, 32);
        chk("b2b_span", last_cyc - first_cyc + 1, 32);

        // Abort after the third pixel
        bq = '{8'hFF, 8'hFF};
        setup(0, 0, 8, 0, 0);
        ends0 = end_cnt;
        en = 1'b1; valid = 1'b1; data = 8'hFF; last = 1'b0;
        for (int t = 0; t < 100 && wr_cnt < 3; t++) begin
            @(negedge clk); #1;
        end
        en = 1'b0; valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_writes", wr_cnt, 3);
        chk("abort_no_end", end_cnt - ends0, 0);
        chk("abort_we_low", we, 0);
        exp_q.delete();

        bq = '{8'($urandom), 8'($urandom)};
        run_sprite(5, 5, 8, 0, 1, 0);

        // Index 0 first, index 5 second
        bq = '{8'h05};
        run_sprite(20, 10, 4, 2, 0, 0);

        // Reserved mode: bytes swallowed, cursor stays put
        bq = '{8'hFF, 8'h12};
        run_sprite(33, 7, 5, 3, 0, 0);

        for (int n = 0; n < 25; n++) begin
            int sx, sy, nb;
            case ($urandom_range(2))
                0:       sx = 630 + $urandom_range(9);
                1:       sx = $urandom_range(1023);
                default: sx = $urandom_range(100);
            endcase
            sy = ($urandom_range(1) == 1) ? 390 + $urandom_range(15) : $urandom_range(1023);
            nb = 1 + $urandom_range(3);
            bq.delete();
            for (int b = 0; b < nb; b++) bq.push_back(8'($urandom));
            run_sprite(sx, sy, $urandom_range(12), $urandom_range(3), $urandom_range(15),
                       ($urandom_range(1) == 1) ? 30 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
